// File: rtl/vc_queue_pkg.sv
// ============================================================================
// Module      : vc_queue_pkg
// Description : Shared beat layout and index-width helpers for the VC queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_queue_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DEST_WIDTH = 4;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] tdata;
    logic                      tlast;
    logic [DEF_ID_WIDTH-1:0]   tid;
    logic [DEF_DEST_WIDTH-1:0] tdest;
  } stored_beat_t;

  // A single VC still needs a one-bit index so port widths never collapse to zero.
  function automatic int vc_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int beat_w(input int data_w, input int id_w, input int dest_w);
    return data_w + 1 + id_w + dest_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_fifo.sv
// ============================================================================
// Module      : vc_fifo
// Description : Single-VC circular FIFO with registered occupancy and almost-full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_fifo #(
  parameter int WIDTH    = 41,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 8,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             af_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      af_q    <= (count_d >= CW'(AF_LEVEL));
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o       = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign almost_full_o = af_q;

endmodule

`default_nettype wire

// File: rtl/vc_cuthrough_queue.sv
// ============================================================================
// Module      : vc_cuthrough_queue
// Description : Per-VC input FIFOs drained by a packet-atomic round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_cuthrough_queue
  import vc_queue_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ID_WIDTH          = 4,
  parameter int DEST_WIDTH        = 4,
  parameter int NUM_VC            = 2,
  parameter int BUFFER_LENGTH     = 16,
  parameter int ALMOST_FULL_LEVEL = 8,
  localparam int VCW              = vc_w(NUM_VC),
  localparam int CW               = $clog2(BUFFER_LENGTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_tdata,
  input  logic                   in_tlast,
  input  logic [ID_WIDTH-1:0]    in_tid,
  input  logic [DEST_WIDTH-1:0]  in_tdest,
  input  logic [VCW-1:0]         in_vc,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [DATA_WIDTH-1:0]  out_tdata,
  output logic                   out_tlast,
  output logic [ID_WIDTH-1:0]    out_tid,
  output logic [DEST_WIDTH-1:0]  out_tdest,
  output logic [VCW-1:0]         out_vc,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [NUM_VC*CW-1:0]   vc_count,
  output logic [NUM_VC-1:0]      vc_almost_full
);

  localparam int BW = beat_w(DATA_WIDTH, ID_WIDTH, DEST_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
  } beat_t;

  beat_t             w_wbeat;
  beat_t             w_sel_beat;
  logic [NUM_VC-1:0] w_push;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_empty;
  logic [BW-1:0]     w_rdata [NUM_VC];
  logic [VCW-1:0]    w_sel;
  logic              w_sel_ok;
  logic              w_load;
  logic [VCW-1:0]    w_rr_next;

  beat_t             out_beat_q;
  logic [VCW-1:0]    out_vc_q;
  logic              out_tvalid_q;
  logic              lock_q;
  logic [VCW-1:0]    lock_vc_q;
  logic [VCW-1:0]    rr_q;

  assign w_wbeat = '{tdata: in_tdata, tlast: in_tlast, tid: in_tid, tdest: in_tdest};

  // Out-of-range VC indices match no FIFO, so they are never accepted.
  always_comb begin
    in_tready = 1'b0;
    w_push    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_vc == VCW'(v)) begin
        in_tready = !w_full[v];
        w_push[v] = in_tvalid && !w_full[v];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      vc_fifo #(
        .WIDTH    (BW),
        .DEPTH    (BUFFER_LENGTH),
        .AF_LEVEL (ALMOST_FULL_LEVEL)
      ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (w_push[g]),
        .wdata_i       (w_wbeat),
        .pop_i         (w_pop[g]),
        .rdata_o       (w_rdata[g]),
        .count_o       (vc_count[g*CW +: CW]),
        .full_o        (w_full[g]),
        .empty_o       (w_empty[g]),
        .almost_full_o (vc_almost_full[g])
      );
    end
  endgenerate

  // Descending scan so the last hit is the first non-empty VC at or after rr_q.
  always_comb begin
    w_sel    = lock_vc_q;
    w_sel_ok = 1'b0;
    if (lock_q) begin
      w_sel_ok = !w_empty[lock_vc_q];
    end else begin
      for (int i = NUM_VC - 1; i >= 0; i--) begin
        for (int v = 0; v < NUM_VC; v++) begin
          if ((v == ((int'(rr_q) + i) % NUM_VC)) && !w_empty[v]) begin
            w_sel    = VCW'(v);
            w_sel_ok = 1'b1;
          end
        end
      end
    end
  end

  assign w_load     = (!out_tvalid_q || out_tready) && w_sel_ok;
  assign w_sel_beat = beat_t'(w_rdata[w_sel]);
  assign w_rr_next  = (w_sel == VCW'(NUM_VC - 1)) ? '0 : (w_sel + VCW'(1));

  always_comb begin
    w_pop = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_pop[v] = w_load && (w_sel == VCW'(v));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat_q   <= '0;
      out_vc_q     <= '0;
      out_tvalid_q <= 1'b0;
      lock_q       <= 1'b0;
      lock_vc_q    <= '0;
      rr_q         <= '0;
    end else if (w_load) begin
      out_beat_q   <= w_sel_beat;
      out_vc_q     <= w_sel;
      out_tvalid_q <= 1'b1;
      if (w_sel_beat.tlast) begin
        lock_q <= 1'b0;
        rr_q   <= w_rr_next;
      end else begin
        lock_q    <= 1'b1;
        lock_vc_q <= w_sel;
      end
    end else if (out_tready) begin
      out_tvalid_q <= 1'b0;
    end
  end

  assign out_tdata  = out_beat_q.tdata;
  assign out_tlast  = out_beat_q.tlast;
  assign out_tid    = out_beat_q.tid;
  assign out_tdest  = out_beat_q.tdest;
  assign out_vc     = out_vc_q;
  assign out_tvalid = out_tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_vc_cuthrough_queue.sv
// ============================================================================
// Module      : tb_vc_cuthrough_queue
// Description : Scoreboard bench for vc_cuthrough_queue with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_cuthrough_queue;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int TW = 4;
  localparam int NV = 2;
  localparam int BL = 16;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_tdata;
  logic          in_tlast;
  logic [IW-1:0] in_tid;
  logic [TW-1:0] in_tdest;
  logic          in_vc;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tlast;
  logic [IW-1:0] out_tid;
  logic [TW-1:0] out_tdest;
  logic          out_vc;
  logic          out_tvalid;
  logic          out_tready;
  logic [NV*CW-1:0] vc_count;
  logic [NV-1:0]    vc_almost_full;

  vc_cuthrough_queue #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(TW),
    .NUM_VC(NV), .BUFFER_LENGTH(BL), .ALMOST_FULL_LEVEL(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tid(in_tid), .in_tdest(in_tdest),
    .in_vc(in_vc), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tid(out_tid), .out_tdest(out_tdest),
    .out_vc(out_vc), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .vc_count(vc_count), .vc_almost_full(vc_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [3:0] tid_of(input logic [31:0] d);
    return d[3:0] ^ 4'h5;
  endfunction

  function automatic logic [3:0] dest_of(input logic [31:0] d);
    return d[7:4];
  endfunction

  function automatic logic [CW-1:0] cnt(input int v);
    return vc_count[v*CW +: CW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l, input logic v);
    exp_t e;
    e.d = d; e.l = l; e.v = v;
    exp_q.push_back(e);
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data 0x%0h vc %0d, expected no beat", out_tdata, out_vc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_tdata !== e.d || out_tlast !== e.l || out_vc !== e.v ||
            out_tid !== tid_of(e.d) || out_tdest !== dest_of(e.d)) begin
          n_err++;
          $display("FAIL beat: got data 0x%0h last %0b vc %0d tid %0h dest %0h, expected data 0x%0h last %0b vc %0d tid %0h dest %0h",
                   out_tdata, out_tlast, out_vc, out_tid, out_tdest,
                   e.d, e.l, e.v, tid_of(e.d), dest_of(e.d));
        end
      end
    end
  end

  // Called and returns at posedge+1; the beat is accepted at the last edge seen.
  task automatic send(input logic v, input logic [31:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    in_vc = v; in_tdata = d; in_tlast = l;
    in_tid = tid_of(d); in_tdest = dest_of(d);
    in_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_tready;
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no acceptance of 0x%0h, expected acceptance", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tid = '0; in_tdest = '0;
    in_vc = 1'b0; in_tvalid = 1'b0; out_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tdata", 64'(out_tdata), 64'd0);
    chk("rst_vc_count", 64'(vc_count), 64'd0);
    chk("rst_almost_full", 64'(vc_almost_full), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd1);

    // Four-beat packet on VC0 with one-edge latency
    out_tready = 1'b1;
    expect_beat(32'h11, 1'b0, 1'b0);
    expect_beat(32'h12, 1'b0, 1'b0);
    expect_beat(32'h13, 1'b0, 1'b0);
    expect_beat(32'h14, 1'b1, 1'b0);
    send(1'b0, 32'h11, 1'b0);
    chk("lat_accept_edge", 64'(out_tvalid), 64'd0);
    send(1'b0, 32'h12, 1'b0);
    chk("lat_next_valid", 64'(out_tvalid), 64'd1);
    chk("lat_next_data", 64'(out_tdata), 64'h11);
    send(1'b0, 32'h13, 1'b0);
    send(1'b0, 32'h14, 1'b1);
    drain();

    // Fill VC1 behind a held output beat
    out_tready = 1'b0;
    expect_beat(32'h20, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) expect_beat(32'h100 + 32'(i), (i == 15), 1'b1);
    expect_beat(32'h21, 1'b1, 1'b0);
    send(1'b0, 32'h20, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 32'h100 + 32'(i), (i == 15));
      if (i == 6) chk("af_below_level", 64'(vc_almost_full[1]), 64'd0);
      if (i == 7) chk("af_at_level", 64'(vc_almost_full[1]), 64'd1);
    end
    chk("vc1_full_count", 64'(cnt(1)), 64'd16);
    in_vc = 1'b1; in_tdata = 32'h1FF; in_tlast = 1'b1; in_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("vc1_full_refuse", 64'(in_tready), 64'd0);
    end
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    send(1'b0, 32'h21, 1'b1);
    chk("vc0_accepts_count", 64'(cnt(0)), 64'd1);
    out_tready = 1'b1;
    drain();

    // Interleaved packets stay atomic
    out_tready = 1'b0;
    expect_beat(32'hA0, 1'b0, 1'b0);
    expect_beat(32'hA1, 1'b0, 1'b0);
    expect_beat(32'hA2, 1'b1, 1'b0);
    expect_beat(32'hB0, 1'b0, 1'b1);
    expect_beat(32'hB1, 1'b1, 1'b1);
    send(1'b0, 32'hA0, 1'b0);
    send(1'b1, 32'hB0, 1'b0);
    send(1'b0, 32'hA1, 1'b0);
    send(1'b1, 32'hB1, 1'b1);
    send(1'b0, 32'hA2, 1'b1);
    out_tready = 1'b1;
    drain();

    // Single-beat packets alternate between VCs
    out_tready = 1'b0;
    expect_beat(32'h40, 1'b1, 1'b0);
    expect_beat(32'h50, 1'b1, 1'b1);
    expect_beat(32'h41, 1'b1, 1'b0);
    expect_beat(32'h51, 1'b1, 1'b1);
    expect_beat(32'h42, 1'b1, 1'b0);
    expect_beat(32'h52, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b0, 32'h40 + 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 32'h50 + 32'(i), 1'b1);
    out_tready = 1'b1;
    drain();

    // Locked VC0 runs dry while VC1 is full
    out_tready = 1'b0;
    expect_beat(32'h60, 1'b0, 1'b0);
    expect_beat(32'h61, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) expect_beat(32'h70 + 32'(i), (i == 15), 1'b1);
    send(1'b0, 32'h60, 1'b0);
    for (int i = 0; i < 16; i++) send(1'b1, 32'h70 + 32'(i), (i == 15));
    out_tready = 1'b1;
    @(posedge clk); #1;
    chk("lock_stall_valid", 64'(out_tvalid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("lock_stall_hold", 64'(out_tvalid), 64'd0);
    chk("lock_stall_vc1", 64'(cnt(1)), 64'd16);
    send(1'b0, 32'h61, 1'b1);
    drain();

    // Reset in the middle of a packet
    out_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 32'h80 + 32'(i), 1'b0);
    chk("pre_rst_valid", 64'(out_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_tvalid), 64'd0);
    chk("mid_rst_count", 64'(vc_count), 64'd0);
    chk("mid_rst_data", 64'(out_tdata), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_tready = 1'b1;
    expect_beat(32'h90, 1'b1, 1'b0);
    send(1'b0, 32'h90, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_rst", 64'(out_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_cuthrough_queue.md
Name: vc_cuthrough_queue

Overview:
Multi-channel successor to the single-channel router input queue. It holds NUM_VC independent circular FIFOs, one per virtual channel, and accepts AXI-Stream beats tagged with a VC index. A packet-atomic round-robin arbiter drains the FIFOs onto a single registered output stream. Sits at each cut-through router input port and exports per-VC occupancy and almost-full flags for upstream flow control.

Parameters:
DATA_WIDTH, 32, TDATA width in bits
ID_WIDTH, 4, TID width
DEST_WIDTH, 4, TDEST width
NUM_VC, 2, number of virtual channels (>=1)
BUFFER_LENGTH, 16, entries per VC; power of two, >=2
ALMOST_FULL_LEVEL, 8, occupancy at or above which vc_almost_full is asserted (1..BUFFER_LENGTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_tdata  in  DATA_WIDTH  input beat data
in_tlast  in  1  last beat of packet
in_tid  in  ID_WIDTH  stream ID
in_tdest  in  DEST_WIDTH  routing destination
in_vc  in  max(1,$clog2(NUM_VC))  target VC of beat; stable while in_tvalid
in_tvalid  in  1  beat valid
in_tready  out  1  beat accepted when high with in_tvalid
out_tdata  out  DATA_WIDTH  registered output data
out_tlast  out  1  registered TLAST
out_tid  out  ID_WIDTH  registered TID
out_tdest  out  DEST_WIDTH  registered TDEST
out_vc  out  max(1,$clog2(NUM_VC))  VC the output beat came from
out_tvalid  out  1  output beat valid
out_tready  in  1  downstream ready
vc_count  out  NUM_VC*($clog2(BUFFER_LENGTH)+1)  per-VC occupancy, VC0 in LSBs
vc_almost_full  out  NUM_VC  per-VC count >= ALMOST_FULL_LEVEL

Behaviour:
- Reset (async assert, sync release): all wr/rd pointers and counts 0; out_tvalid 0; out_* data 0; out_vc 0; lock cleared; RR pointer 0; vc_almost_full 0; storage not reset.
- Per VC: wr_ptr, rd_ptr of $clog2(BUFFER_LENGTH) bits, wrap naturally; count of $clog2(BUFFER_LENGTH)+1 bits; full = count==BUFFER_LENGTH, empty = count==0.
- in_tready = !full[in_vc], combinational from registered count only; never depends on out_tready. A beat offered to a full VC is not accepted even if that VC pops in the same cycle.
- in_vc >= NUM_VC: in_tready=0, beat never accepted (bench must not hold it forever).
- Output stage: a single register. Load when (!out_tvalid || out_tready) and selected VC non-empty; otherwise out_tvalid clears on out_tready if nothing to load. Out data stable while out_tvalid && !out_tready.
- Latency: beat accepted at edge k into an empty, unlocked-idle queue appears on out_tvalid after edge k+1. No combinational bypass. Sustained throughput 1 beat/cycle per stream.
- Arbitration: when unlocked, grant lowest-index non-empty VC at or after RR pointer. On load of a non-TLAST beat, lock to that VC. Locked: only that VC is read; stall (no load) while it is empty. On load of a TLAST beat: unlock, RR pointer = granted VC + 1 (mod NUM_VC).
- Simultaneous push and pop on the same VC: count unchanged, both pointers advance.
- vc_count / vc_almost_full are registered, reflect post-edge counts.
- Reset mid-packet: all contents and lock discarded; no partial beat emitted afterwards.

Decomposition:
- Package vc_queue_pkg: stored_beat_t packed struct {tdata, tlast, tid, tdest}; function vc_w(NUM_VC) for index width.
- Sub-module vc_fifo (one per VC, generate loop): storage, pointers, count, full/empty, almost_full. Top holds RR arbiter, lock, output register.

Test Plan:
- Reset then 4 beats on VC0 (0x11..0x14, last on 0x14), out_tready=1 -> out_tdata 0x11..0x14 on consecutive cycles, first one edge after acceptance, out_vc=0.
- VC1 filled with 16 beats, out_tready=0 -> in_tready low on 17th offer, vc_count[VC1]=16, vc_almost_full[1] set at count 8; VC0 still accepts.
- Interleave: VC0 3-beat packet A, VC1 2-beat packet B written alternately -> output A0 A1 A2 B0 B1, never mixed.
- Both VCs hold 1-beat packets continuously -> output alternates VC0, VC1, VC0...
- Locked VC0 mid-packet empties while VC1 full -> out_tvalid drops, VC1 not served until VC0 TLAST beat emitted.
- rst_n pulsed low mid-packet with 5 beats queued -> out_tvalid 0 immediately, counts 0, new beat after release emitted normally.
